id_ex_hazard_ctrl: RTL and testbench
====================================

# id_ex_hazard_ctrl

Pipeline hazard controller that drives the ID/EX register's control inputs and the front-end write enables. It reads back the EX-stage mem-read flag and RT address held in ID/EX, and detects load-use hazards against the instruction in ID. On a hazard it freezes PC and IF/ID and inserts a bubble by zeroing the WB/M/EX bundles. On a taken branch or jump it flushes IF/ID. It sits between the ID-stage decoder and ID/EX.

## Interface
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard; legal range 1–7.
- clk_i  in  1  pipeline clock; all state updates on posedge.
- rst_n_i  in  1  asynchronous active-low reset.
- id_rs_addr_i  in  5  RS address of the instruction in ID.
- id_rt_addr_i  in  5  RT address of the instruction in ID.
- id_uses_rs_i  in  1  ID instruction reads RS.
- id_uses_rt_i  in  1  ID instruction reads RT.
- ex_memread_i  in  1  ID/EX mem-read flag (M bit 0) of the instruction in EX.
- ex_rt_addr_i  in  5  ID/EX RT address of the instruction in EX.
- branch_taken_i  in  1  branch or jump resolved taken in ID.
- WB_i  in  2  decoder WB bundle.
- M_i  in  2  decoder M bundle; bit 0 is MemRead.
- EX_i  in  4  decoder EX bundle: bit 3 RegDst, bits 2:1 ALUOp, bit 0 ALUSrc.
- WB_o  out  2  WB bundle to ID/EX.
- M_o  out  2  M bundle to ID/EX.
- EX_o  out  4  EX bundle to ID/EX.
- pc_write_o  out  1  PC update enable.
- ifid_write_o  out  1  IF/ID load enable.
- ifid_flush_o  out  1  IF/ID clear (inserts a nop).
- stall_o  out  1  a bubble is being inserted this cycle.
- stall_cnt_o  out  32  total bubble count. Present only with the macro.

## Operation
- Hazard is combinational. It is 1 when all of the following hold:
  - ex_memread_i = 1.
  - ex_rt_addr_i ≠ 0.
  - Either (id_uses_rs_i and ex_rt_addr_i == id_rs_addr_i) or (id_uses_rt_i and ex_rt_addr_i == id_rt_addr_i).
- State machine has two states, RUN and HOLD, plus a 3-bit counter cnt.
- RUN, hazard = 1:
  - stall_o = 1, pc_write_o = 0, ifid_write_o = 0, ifid_flush_o = 0.
  - WB_o, M_o and EX_o are all 0.
  - If LOAD_STALL_CYCLES > 1: next state HOLD, cnt ← LOAD_STALL_CYCLES − 2. Otherwise stay in RUN.
- RUN, hazard = 0:
  - Bundles pass through unchanged; pc_write_o = 1, ifid_write_o = 1, stall_o = 0.
  - ifid_flush_o = branch_taken_i.
- HOLD:
  - Outputs identical to the hazard case, regardless of inputs. branch_taken_i is ignored.
  - If cnt == 0: next state RUN. Otherwise cnt ← cnt − 1.
- Priority: hazard beats branch_taken_i. A stalled branch is re-evaluated after release; the branch operand may depend on the load.
- The hazard clears by itself once the bubble reaches ID/EX (ex_memread_i = 0 next cycle). No hazard state is latched in RUN.
- A hazard arising in the same cycle HOLD exits is evaluated normally in RUN on the following cycle.

## Timing
- Control outputs are a combinational function of the current state and inputs, with zero-cycle latency.
- Each load-use hazard costs exactly LOAD_STALL_CYCLES bubble cycles, measured from first detection.
- Reset asserted (asynchronous): state ← RUN, cnt ← 0, stall_cnt_o ← 0.
- While rst_n_i = 0, outputs are forced:
  - pc_write_o = 0, ifid_write_o = 0, ifid_flush_o = 1, stall_o = 0.
  - WB_o, M_o and EX_o are all 0.
- Reset asserted mid-HOLD aborts the stall immediately.
- After rst_n_i deasserts, the first posedge operates in RUN.
- stall_cnt_o increments on every posedge where stall_o = 1. It wraps 0xFFFFFFFF → 0.

## Configuration
- HAZARD_STALL_CNT_EN defined: the stall_cnt_o port and its 32-bit counter exist.
- HAZARD_STALL_CNT_EN undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Load-use on RS: ex_memread_i = 1, ex_rt_addr_i = 8, id_rs_addr_i = 8, id_uses_rs_i = 1, LOAD_STALL_CYCLES = 1 → one cycle with stall_o = 1, pc_write_o = 0, bundles 0; next cycle (ex_memread_i = 0) pass-through with pc_write_o = 1.
- $zero exemption: ex_rt_addr_i = 0 = id_rt_addr_i, id_uses_rt_i = 1, ex_memread_i = 1 → no stall; WB_o = WB_i = 2'b10.
- Branch only: branch_taken_i = 1, no hazard → ifid_flush_o = 1, pc_write_o = 1, bundles pass through.
- Simultaneous hazard and branch: branch_taken_i = 1 plus an RT match → ifid_flush_o = 0, stall_o = 1; after the hazard clears, flush asserts when branch_taken_i is still 1.
- LOAD_STALL_CYCLES = 3, hazard for one cycle only → stall_o high for exactly 3 consecutive cycles; stall_cnt_o goes 0 → 3 with the macro defined.
- Reset mid-HOLD: rst_n_i low in the 2nd of 3 stall cycles → ifid_flush_o = 1 immediately, stall_cnt_o = 0; after release, RUN with no residual stall.

Source files
------------

// File: rtl/id_ex_hazard_if.sv
// Signal bundle between the ID-stage decoder/front end and the ID/EX hazard controller.
interface id_ex_hazard_if;
    logic [4:0] id_rs_addr_i;
    logic [4:0] id_rt_addr_i;
    logic       id_uses_rs_i;
    logic       id_uses_rt_i;
    logic       ex_memread_i;
    logic [4:0] ex_rt_addr_i;
    logic       branch_taken_i;
    logic [1:0] WB_i;
    logic [1:0] M_i;
    logic [3:0] EX_i;
    logic [1:0] WB_o;
    logic [1:0] M_o;
    logic [3:0] EX_o;
    logic       pc_write_o;
    logic       ifid_write_o;
    logic       ifid_flush_o;
    logic       stall_o;

    modport master (
        output id_rs_addr_i, id_rt_addr_i, id_uses_rs_i, id_uses_rt_i,
        output ex_memread_i, ex_rt_addr_i, branch_taken_i, WB_i, M_i, EX_i,
        input  WB_o, M_o, EX_o, pc_write_o, ifid_write_o, ifid_flush_o, stall_o
    );

    modport slave (
        input  id_rs_addr_i, id_rt_addr_i, id_uses_rs_i, id_uses_rt_i,
        input  ex_memread_i, ex_rt_addr_i, branch_taken_i, WB_i, M_i, EX_i,
        output WB_o, M_o, EX_o, pc_write_o, ifid_write_o, ifid_flush_o, stall_o
    );
endinterface

// File: rtl/id_ex_hazard_ctrl.sv
// Load-use hazard / branch flush controller feeding the ID/EX register and front-end enables.
// Define HAZARD_STALL_CNT_EN to add the 32-bit stall_cnt_o bubble counter.
module id_ex_hazard_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    id_ex_hazard_if.slave        bus
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [31:0]          stall_cnt_o
`endif
);

    typedef enum logic {RUN, HOLD} state_t;

    localparam bit         MULTI_STALL = (LOAD_STALL_CYCLES > 1);
    localparam logic [2:0] HOLD_INIT   = MULTI_STALL ? 3'(LOAD_STALL_CYCLES - 2) : 3'd0;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       rs_hit, rt_hit, hazard;
    logic       bubble, flush;

    assign rs_hit = bus.id_uses_rs_i && (bus.ex_rt_addr_i == bus.id_rs_addr_i);
    assign rt_hit = bus.id_uses_rt_i && (bus.ex_rt_addr_i == bus.id_rt_addr_i);
    assign hazard = bus.ex_memread_i && (bus.ex_rt_addr_i != 5'd0) && (rs_hit || rt_hit);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Hazard outranks a taken branch: the branch is re-evaluated once the load has cleared.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bubble  = 1'b0;
        flush   = 1'b0;
        case (state_q)
            RUN: begin
                if (hazard) begin
                    bubble = 1'b1;
                    if (MULTI_STALL) begin
                        state_d = HOLD;
                        cnt_d   = HOLD_INIT;
                    end
                end else begin
                    flush = bus.branch_taken_i;
                end
            end
            HOLD: begin
                bubble = 1'b1;
                if (cnt_q == 3'd0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // Reset overrides everything so the front end holds a nop while the pipeline is down.
    always_comb begin
        bus.WB_o         = 2'b00;
        bus.M_o          = 2'b00;
        bus.EX_o         = 4'b0000;
        bus.pc_write_o   = 1'b0;
        bus.ifid_write_o = 1'b0;
        bus.ifid_flush_o = 1'b1;
        bus.stall_o      = 1'b0;
        if (rst_n_i) begin
            bus.stall_o      = bubble;
            bus.ifid_flush_o = flush;
            bus.pc_write_o   = !bubble;
            bus.ifid_write_o = !bubble;
            if (!bubble) begin
                bus.WB_o = bus.WB_i;
                bus.M_o  = bus.M_i;
                bus.EX_o = bus.EX_i;
            end
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_q <= 32'd0;
        end else if (bubble) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// Scoreboard bench for id_ex_hazard_ctrl: one instance with single-cycle stalls, one with three.
module tb_id_ex_hazard_ctrl;

    logic clk_i = 1'b0;
    logic rst_n_i;

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       mr;
        logic [4:0] exrt;
        logic       br;
        logic [1:0] wb;
        logic [1:0] m;
        logic [3:0] ex;
    } in_t;

    typedef struct {
        int          id;
        bit          dut;
        logic [11:0] outs;
        logic [31:0] cnt;
        bit          chk_cnt;
    } exp_t;

    in_t  in_a, in_b;
    exp_t q[$];
    exp_t cur;
    int   n_vec = 0;
    int   n_err = 0;
    int   vid   = 0;

    id_ex_hazard_if bus_a();
    id_ex_hazard_if bus_b();

    assign bus_a.id_rs_addr_i   = in_a.rs;
    assign bus_a.id_rt_addr_i   = in_a.rt;
    assign bus_a.id_uses_rs_i   = in_a.urs;
    assign bus_a.id_uses_rt_i   = in_a.urt;
    assign bus_a.ex_memread_i   = in_a.mr;
    assign bus_a.ex_rt_addr_i   = in_a.exrt;
    assign bus_a.branch_taken_i = in_a.br;
    assign bus_a.WB_i           = in_a.wb;
    assign bus_a.M_i            = in_a.m;
    assign bus_a.EX_i           = in_a.ex;

    assign bus_b.id_rs_addr_i   = in_b.rs;
    assign bus_b.id_rt_addr_i   = in_b.rt;
    assign bus_b.id_uses_rs_i   = in_b.urs;
    assign bus_b.id_uses_rt_i   = in_b.urt;
    assign bus_b.ex_memread_i   = in_b.mr;
    assign bus_b.ex_rt_addr_i   = in_b.exrt;
    assign bus_b.branch_taken_i = in_b.br;
    assign bus_b.WB_i           = in_b.wb;
    assign bus_b.M_i            = in_b.m;
    assign bus_b.EX_i           = in_b.ex;

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] cnt_a, cnt_b;
`endif

    id_ex_hazard_ctrl #(.LOAD_STALL_CYCLES(1)) dut_a (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus_a)
`ifdef HAZARD_STALL_CNT_EN
        ,
        .stall_cnt_o (cnt_a)
`endif
    );

    id_ex_hazard_ctrl #(.LOAD_STALL_CYCLES(3)) dut_b (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus_b)
`ifdef HAZARD_STALL_CNT_EN
        ,
        .stall_cnt_o (cnt_b)
`endif
    );

    logic [11:0] out_a, out_b;
    assign out_a = {bus_a.WB_o, bus_a.M_o, bus_a.EX_o, bus_a.pc_write_o,
                    bus_a.ifid_write_o, bus_a.ifid_flush_o, bus_a.stall_o};
    assign out_b = {bus_b.WB_o, bus_b.M_o, bus_b.EX_o, bus_b.pc_write_o,
                    bus_b.ifid_write_o, bus_b.ifid_flush_o, bus_b.stall_o};

    // Drive one vector into the chosen instance and queue its hand-computed response.
    task automatic apply(input bit d, input bit rst,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input bit urs, input bit urt, input bit mr,
                         input logic [4:0] exrt, input bit br,
                         input logic [1:0] wb, input logic [1:0] m, input logic [3:0] ex,
                         input bit e_stall, input bit e_flush,
                         input logic [31:0] e_cnt, input bit chk);
        in_t  v;
        exp_t e;
        v = '{rs: rs, rt: rt, urs: urs, urt: urt, mr: mr, exrt: exrt,
              br: br, wb: wb, m: m, ex: ex};
        @(posedge clk_i);
        #1;
        rst_n_i = rst;
        if (d) begin
            in_b = v;
            in_a = '0;
        end else begin
            in_a = v;
            in_b = '0;
        end
        e.id      = vid;
        e.dut     = d;
        e.cnt     = e_cnt;
        e.chk_cnt = chk;
        if (!rst)
            e.outs = {8'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        else if (e_stall)
            e.outs = {8'b0, 1'b0, 1'b0, e_flush, 1'b1};
        else
            e.outs = {wb, m, ex, 1'b1, 1'b1, e_flush, 1'b0};
        q.push_back(e);
        vid++;
    endtask

    always @(negedge clk_i) begin
        if (q.size() > 0) begin
            logic [11:0] act;
            cur = q.pop_front();
            act = cur.dut ? out_b : out_a;
            n_vec++;
            if (act !== cur.outs) begin
                n_err++;
                $display("FAIL vec%0d dut%0d outs{WB,M,EX,pcw,ifidw,flush,stall}: got %b want %b",
                         cur.id, cur.dut, act, cur.outs);
            end
`ifdef HAZARD_STALL_CNT_EN
            if (cur.chk_cnt) begin
                logic [31:0] acnt;
                acnt = cur.dut ? cnt_b : cnt_a;
                n_vec++;
                if (acnt !== cur.cnt) begin
                    n_err++;
                    $display("FAIL vec%0d dut%0d stall_cnt_o: got %0d want %0d",
                             cur.id, cur.dut, acnt, cur.cnt);
                end
            end
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n_i = 1'b0;
        in_a    = '0;
        in_b    = '0;
        //     d  rst rs     rt     urs urt mr exrt   br wb     m      ex       stl fl cnt    chk
        // reset state on both instances
        apply(0, 0, 5'd0,  5'd0,  0,  0,  0, 5'd0,  0, 2'b00, 2'b00, 4'b0000, 0,  1, 32'd0, 1);
        apply(1, 0, 5'd0,  5'd0,  0,  0,  0, 5'd0,  0, 2'b00, 2'b00, 4'b0000, 0,  1, 32'd0, 1);
        // LOAD_STALL_CYCLES = 1
        apply(0, 1, 5'd3,  5'd4,  1,  1,  0, 5'd4,  0, 2'b11, 2'b01, 4'b1011, 0,  0, 32'd0, 0);
        apply(0, 1, 5'd8,  5'd2,  1,  0,  1, 5'd8,  0, 2'b10, 2'b10, 4'b1100, 1,  0, 32'd0, 0);
        apply(0, 1, 5'd8,  5'd2,  1,  0,  0, 5'd8,  0, 2'b10, 2'b10, 4'b1100, 0,  0, 32'd0, 0);
        apply(0, 1, 5'd1,  5'd0,  0,  1,  1, 5'd0,  0, 2'b10, 2'b01, 4'b0001, 0,  0, 32'd0, 0);
        apply(0, 1, 5'd8,  5'd3,  0,  1,  1, 5'd8,  0, 2'b01, 2'b11, 4'b1110, 0,  0, 32'd0, 0);
        apply(0, 1, 5'd7,  5'd5,  0,  1,  0, 5'd5,  0, 2'b11, 2'b00, 4'b0010, 0,  0, 32'd0, 0);
        apply(0, 1, 5'd7,  5'd6,  1,  1,  0, 5'd9,  1, 2'b01, 2'b00, 4'b0110, 0,  1, 32'd0, 0);
        apply(0, 1, 5'd7,  5'd5,  1,  1,  1, 5'd5,  1, 2'b11, 2'b01, 4'b1001, 1,  0, 32'd0, 0);
        apply(0, 1, 5'd7,  5'd5,  1,  1,  0, 5'd5,  1, 2'b11, 2'b01, 4'b1001, 0,  1, 32'd0, 0);
        apply(0, 1, 5'd2,  5'd17, 0,  1,  1, 5'd17, 0, 2'b10, 2'b10, 4'b0100, 1,  0, 32'd0, 0);
        apply(0, 1, 5'd2,  5'd17, 0,  1,  1, 5'd17, 0, 2'b10, 2'b10, 4'b0100, 1,  0, 32'd0, 0);
        // LOAD_STALL_CYCLES = 3: single-cycle hazard gives three bubbles, branch ignored in HOLD
        apply(1, 1, 5'd9,  5'd1,  1,  0,  1, 5'd9,  0, 2'b11, 2'b11, 4'b1111, 1,  0, 32'd0, 1);
        apply(1, 1, 5'd9,  5'd1,  1,  0,  0, 5'd9,  1, 2'b11, 2'b11, 4'b1111, 1,  0, 32'd1, 1);
        apply(1, 1, 5'd9,  5'd1,  1,  0,  0, 5'd9,  0, 2'b11, 2'b11, 4'b1111, 1,  0, 32'd2, 1);
        apply(1, 1, 5'd9,  5'd1,  1,  0,  0, 5'd9,  0, 2'b01, 2'b10, 4'b0101, 0,  0, 32'd3, 1);
        // reset in the second stall cycle aborts the stall
        apply(1, 1, 5'd4,  5'd12, 0,  1,  1, 5'd12, 0, 2'b10, 2'b01, 4'b0011, 1,  0, 32'd3, 1);
        apply(1, 0, 5'd4,  5'd12, 0,  1,  1, 5'd12, 1, 2'b10, 2'b01, 4'b0011, 0,  1, 32'd0, 1);
        apply(1, 1, 5'd4,  5'd12, 0,  1,  0, 5'd12, 0, 2'b10, 2'b01, 4'b0011, 0,  0, 32'd0, 1);
        apply(1, 1, 5'd4,  5'd12, 0,  1,  0, 5'd12, 0, 2'b01, 2'b11, 4'b1000, 0,  0, 32'd0, 1);
        // hazard still present on HOLD exit starts a fresh stall
        apply(1, 1, 5'd6,  5'd0,  1,  0,  1, 5'd6,  0, 2'b11, 2'b10, 4'b0111, 1,  0, 32'd0, 1);
        apply(1, 1, 5'd6,  5'd0,  1,  0,  1, 5'd6,  0, 2'b11, 2'b10, 4'b0111, 1,  0, 32'd1, 1);
        apply(1, 1, 5'd6,  5'd0,  1,  0,  1, 5'd6,  0, 2'b11, 2'b10, 4'b0111, 1,  0, 32'd2, 1);
        apply(1, 1, 5'd6,  5'd0,  1,  0,  1, 5'd6,  0, 2'b11, 2'b10, 4'b0111, 1,  0, 32'd3, 1);
        apply(1, 1, 5'd6,  5'd0,  1,  0,  0, 5'd6,  0, 2'b11, 2'b10, 4'b0111, 1,  0, 32'd4, 1);
        apply(1, 1, 5'd6,  5'd0,  1,  0,  0, 5'd6,  0, 2'b11, 2'b10, 4'b0111, 1,  0, 32'd5, 1);
        apply(1, 1, 5'd6,  5'd0,  1,  0,  0, 5'd6,  1, 2'b11, 2'b10, 4'b0111, 0,  1, 32'd6, 1);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk_i);
        if (q.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d expected responses never checked, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
